// File: rtl/nibble_serial_adder_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_if
//   Request/result bundle for the nibble-serial adder.
//
//   Parameter:
//     N_NIB  number of 4-bit nibbles per operand (W = 4*N_NIB)
//
//   Signals:
//     start  request: sample a, b, cin and begin an addition
//     a, b   W-bit operands (unsigned or two's complement)
//     cin    carry into nibble 0
//     busy   addition in progress
//     done   one-cycle pulse, sum/cout/ovf just updated
//     sum    a+b+cin mod 2^W
//     cout   carry out of the MSB nibble
//     ovf    two's-complement overflow of the result
//
//   Modports:
//     master  requester side (drives start/a/b/cin)
//     slave   adder side (drives busy/done/sum/cout/ovf)
// ---------------------------------------------------------------------------
interface nibble_serial_adder_if #(
  parameter int N_NIB = 4
) ();
  localparam int W = 4 * N_NIB;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//   Adds two W-bit operands plus a carry-in using one 4-bit adder stage,
//   one nibble per clock, least significant nibble first.  A new request is
//   accepted in IDLE or DONE; results appear N_NIB+1 edges after acceptance.
//
//   Parameter:
//     N_NIB  nibbles per operand, 1..8 (W = 4*N_NIB)
//
//   Ports:
//     clk    sole clock, rising edge
//     rst    synchronous active-high reset
//     bus    nibble_serial_adder_if.slave (start/a/b/cin in,
//            busy/done/sum/cout/ovf out)
// ---------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int N_NIB = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);
  localparam int W = 4 * N_NIB;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_NIB = 4'(N_NIB - 1);

  logic [1:0]   state_q, state_d;
  // The A shift register doubles as the result shift register: each result
  // nibble enters at the top while the consumed A nibble leaves the bottom.
  // After N_NIB shifts it holds the complete sum.
  logic [W-1:0] ar_q, ar_d;
  logic [W-1:0] b_q, b_d;
  logic         carry_q, carry_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;

  logic [4:0]   nib_add;
  logic [W-1:0] ar_shift;

  // The single 4-bit add stage.
  assign nib_add = {1'b0, ar_q[3:0]} + {1'b0, b_q[3:0]} + {4'd0, carry_q};

  generate
    if (N_NIB == 1) begin : g_single
      assign ar_shift = nib_add[3:0];
    end else begin : g_multi
      assign ar_shift = {nib_add[3:0], ar_q[W-1:4]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          ar_d    = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = 4'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        ar_d    = ar_shift;
        b_d     = b_q >> 4;
        carry_d = nib_add[4];
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LAST_NIB) begin
          state_d = DONE;
          sum_d   = ar_shift;
          cout_d  = nib_add[4];
          // On the last nibble ar_q[3]/b_q[3] are still the original operand
          // sign bits, and nib_add[3] is the result sign bit.
          ovf_d   = (ar_q[3] == b_q[3]) && (nib_add[3] != ar_q[3]);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ar_q    <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= 4'd0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: N_NIB, 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB; legal range 1..8.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request: sample a, b, cin and begin an addition.
REQ-006 a  input  W  operand A, unsigned or two's complement.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry into nibble 0.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse: sum/cout/ovf just updated.
REQ-011 sum  output  W  result a+b+cin mod 2^W.
REQ-012 cout  output  1  carry out of the MSB nibble.
REQ-013 ovf  output  1  two's-complement overflow of the result.

Function
REQ-014 The block SHALL use a single 4-bit add stage ({c,s} = x + y + c_in) reused once per cycle, LSB nibble first; no W-bit adder.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE: start=1 at edge E0 -> latch a, b into internal shift registers, load carry register with cin, clear nibble counter, go RUN.
REQ-017 RUN: at each edge compute the current low nibble of A and B plus the carry register, store the 4-bit result into the result shift register, store the new carry, shift A/B right by 4, increment the counter.
REQ-018 Nibble i (i = 0..N_NIB-1) SHALL be computed at edge E(i+1); after edge E(N_NIB) the FSM SHALL be in DONE.
REQ-019 On entry to DONE, sum, cout and ovf SHALL update together from the internal registers; done=1 for exactly the cycle after E(N_NIB).
REQ-020 Latency: done high N_NIB+1 edges after the accepting start edge (5 cycles at N_NIB=4).
REQ-021 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-022 ovf SHALL be 1 iff a[W-1]==b[W-1] and sum[W-1]!=a[W-1], evaluated on the latched operands.
REQ-023 start SHALL be ignored while busy=1; operand changes during RUN SHALL NOT affect the result.
REQ-024 In DONE, start=1 SHALL be accepted exactly as in IDLE (back-to-back, no dead cycle); otherwise DONE -> IDLE.
REQ-025 sum, cout and ovf SHALL hold their values from the last completed addition until the next DONE entry or rst; they SHALL NOT change during RUN.
REQ-026 Operand values SHALL be unrestricted; all-ones inputs with cin=1 SHALL ripple carry correctly through every nibble.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry and internal registers.
REQ-028 rst takes priority over start and over any in-flight addition; an aborted addition SHALL NOT produce done.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 Basic add: N_NIB=4, a=0x1234, b=0x4321, cin=0, one-cycle start -> busy high 4 cycles, done pulse at edge 5, sum=0x5555, cout=0, ovf=0.
REQ-031 Full ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; a=0xFFFF, b=0x0001, cin=0 -> same result.
REQ-032 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-033 Busy rejection: start with a=0x0001, b=0x0001, then start=1 with a=0xAAAA during RUN -> result 0x0002, exactly one done pulse.
REQ-034 Reset mid-operation: rst at edge 2 of an addition -> all outputs 0 next cycle, no done; then start a=0x0F0F, b=0x00F1 -> sum=0x1000, cout=0.
REQ-035 Back-to-back: start held high through the done cycle -> second addition accepted at the done edge, second done exactly 5 cycles after the first; both results correct against a golden a+b+cin model.
